// File: rtl/mem_access_unit_if.sv
// Request/response and RAM pin bundle for mem_access_unit.
// The slave modport is the unit's view; master is the CPU/RAM side.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [1:0]            i_req_size;
  logic                  i_req_signed;
  logic [31:0]           i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_resp_valid;
  logic [DATA_WIDTH-1:0] o_resp_rdata;
  logic                  o_err;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_data;
  logic                  o_ram_we;
  logic [DATA_WIDTH-1:0] i_ram_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata, i_ram_data,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_err, o_ram_addr, o_ram_data, o_ram_we
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata, i_ram_data,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_err, o_ram_addr, o_ram_data, o_ram_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store initiator for a single-port word RAM without byte enables.
// Optional MEM_ACCESS_ALIGN_CHECK_EN: misaligned half/word accesses error out instead of being force-aligned.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ram_we;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_req_err;
  logic [1:0]            w_req_off;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [ADDR_WIDTH-1:0] w_ram_addr_n;
  logic [DATA_WIDTH-1:0] w_ram_data_n;
  logic [DATA_WIDTH-1:0] w_resp_rdata_n;
  logic                  w_err_n;
  logic                  w_unused;

  // Address bits above the RAM range alias by design.
  assign w_unused = &{1'b0, bus.i_req_addr[31:ADDR_WIDTH+2]};

  assign w_accept = bus.i_req_valid && (r_state == IDLE);

  // Request classification and effective byte offset within the word.
  always_comb begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    w_req_err = (bus.i_req_size == 2'b11)
              | ((bus.i_req_size == 2'b01) & bus.i_req_addr[0])
              | ((bus.i_req_size == 2'b10) & (|bus.i_req_addr[1:0]));
`else
    w_req_err = (bus.i_req_size == 2'b11);
`endif
    case (bus.i_req_size)
      2'b00:   w_req_off = bus.i_req_addr[1:0];
      2'b01:   w_req_off = {bus.i_req_addr[1], 1'b0};
      default: w_req_off = 2'b00;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  assign w_shamt = {r_off, 3'b000};
  assign w_lane  = bus.i_ram_data >> w_shamt;

  always_comb begin
    case (r_size)
      2'b00:   w_load_data = {{(DATA_WIDTH-8){r_signed & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load_data = {{(DATA_WIDTH-16){r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load_data = bus.i_ram_data;
    endcase
  end

  assign w_mask   = ((r_size == 2'b00) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << w_shamt;
  assign w_merged = (bus.i_ram_data & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  // Next state and next values of the registered outputs.
  always_comb begin
    w_next_state   = r_state;
    w_ram_addr_n   = r_ram_addr;
    w_ram_data_n   = r_ram_data;
    w_resp_rdata_n = '0;
    w_err_n        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_req_valid) begin
          if (w_req_err) begin
            w_next_state = RESP;
            w_err_n      = 1'b1;
          end else begin
            w_ram_addr_n = bus.i_req_addr[ADDR_WIDTH+1:2];
            if (bus.i_req_we && (bus.i_req_size == 2'b10)) begin
              w_next_state = WR_ISSUE;
              w_ram_data_n = bus.i_req_wdata;
            end else begin
              w_next_state = RD_ISSUE;
            end
          end
        end
      end
      RD_ISSUE:   w_next_state = RD_CAPTURE;
      RD_CAPTURE: begin
        if (r_we) begin
          w_next_state = WR_ISSUE;
          w_ram_data_n = w_merged;
        end else begin
          w_next_state   = RESP;
          w_resp_rdata_n = w_load_data;
        end
      end
      WR_ISSUE:   w_next_state = RESP;
      RESP:       w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ram_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ram_addr   <= w_ram_addr_n;
      r_ram_data   <= w_ram_data_n;
      r_ram_we     <= (w_next_state == WR_ISSUE);
      r_resp_valid <= (w_next_state == RESP);
      r_resp_rdata <= w_resp_rdata_n;
      r_err        <= w_err_n;
      if (w_accept) begin
        r_we     <= bus.i_req_we;
        r_size   <= bus.i_req_size;
        r_signed <= bus.i_req_signed;
        r_off    <= w_req_off;
        r_wdata  <= bus.i_req_wdata;
      end
    end
  end

  assign bus.o_req_ready  = (r_state == IDLE);
  assign bus.o_ram_addr   = r_ram_addr;
  assign bus.o_ram_data   = r_ram_data;
  assign bus.o_ram_we     = r_ram_we;
  assign bus.o_resp_valid = r_resp_valid;
  assign bus.o_resp_rdata = r_resp_rdata;
  assign bus.o_err        = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural RAM and a byte-level reference model.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    int          wait_cyc;
  } obs_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   wr_cnt;
  logic [9:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] ram [1024] = '{default: 32'h0};
  logic [31:0] ref_mem [1024];
  bit align_en;

  mem_access_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with read-before-write, plus a write monitor.
  always @(posedge clk) begin
    if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_data;
    bus.i_ram_data <= ram[bus.o_ram_addr];
  end

  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (bus.o_ram_we) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.o_ram_addr;
      last_wr_data <= bus.o_ram_data;
    end
  end

  // Reference: expected outcome of one request, updating the shadow memory for stores.
  task automatic model_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, output obs_t e);
    int unsigned widx, off;
    logic [31:0] word, mask, v;
    bit mis;
    widx = (addr / 4) % 1024;
    off  = addr % 4;
    mis  = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
    e.err = (size == 2'd3) || (align_en && mis);
    e.rdata = 32'h0; e.nwr = 0; e.wr_addr = 10'h0; e.wr_data = 32'h0; e.wait_cyc = 0;
    if (size == 2'd1) off = off - (off % 2);
    if (size == 2'd2) off = 0;
    mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 3;
      v = (ref_mem[widx] >> (8 * off)) & mask;
      if (sgn && size == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (sgn && size == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      e.rdata = v;
    end else begin
      e.lat = (size == 2'd2) ? 2 : 4;
      word = ref_mem[widx];
      word = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      ref_mem[widx] = word;
      e.nwr = 1;
      e.wr_addr = 10'(widx);
      e.wr_data = word;
    end
  endtask

  // Drives one request from a negedge and observes its response; returns at a negedge.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
    int base;
    bus.i_req_we = we; bus.i_req_size = size; bus.i_req_signed = sgn;
    bus.i_req_addr = addr; bus.i_req_wdata = wdata; bus.i_req_valid = 1'b1;
    o.wait_cyc = 0; o.rdata = 32'h0; o.err = 1'b0; o.lat = -1;
    while (!bus.o_req_ready && o.wait_cyc < 20) begin
      @(negedge clk);
      o.wait_cyc++;
    end
    base = wr_cnt;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_we = 1'($urandom); bus.i_req_size = 2'($urandom); bus.i_req_signed = 1'($urandom);
    bus.i_req_addr = $urandom; bus.i_req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.o_resp_valid) begin
        o.lat = k; o.rdata = bus.o_resp_rdata; o.err = bus.o_err;
        break;
      end
    end
    o.nwr = wr_cnt - base; o.wr_addr = last_wr_addr; o.wr_data = last_wr_data;
  endtask

  task automatic test_reset;
    bus.i_req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (bus.o_req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.o_req_ready); else n_pass++;
    n_total++; if (bus.o_resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", bus.o_resp_valid); else n_pass++;
    n_total++; if (bus.o_ram_we !== 1'b0) $display("FAIL reset_ram_we got %b exp 0", bus.o_ram_we); else n_pass++;
    n_total++; if (bus.o_ram_addr !== 10'h0) $display("FAIL reset_ram_addr got %h exp 0", bus.o_ram_addr); else n_pass++;
    n_total++; if (bus.o_ram_data !== 32'h0) $display("FAIL reset_ram_data got %h exp 0", bus.o_ram_data); else n_pass++;
    n_total++; if ({bus.o_err, bus.o_resp_rdata} !== 33'h0) $display("FAIL reset_err_rdata got %b/%h exp 0/0", bus.o_err, bus.o_resp_rdata); else n_pass++;
  endtask

  task automatic test_word;
    obs_t o, e;
    model_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, e);
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, o);
    n_total++; if (o.lat !== 2) $display("FAIL word_st_lat got %0d exp 2", o.lat); else n_pass++;
    n_total++; if (o.nwr !== 1 || o.wr_addr !== 10'd4 || o.wr_data !== 32'hDEADBEEF)
      $display("FAIL word_st_write got n=%0d a=%h d=%h exp n=1 a=004 d=deadbeef", o.nwr, o.wr_addr, o.wr_data); else n_pass++;
    n_total++; if (o.err !== 1'b0 || o.rdata !== 32'h0) $display("FAIL word_st_resp got err=%b rd=%h exp 0/0", o.err, o.rdata); else n_pass++;
    model_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o);
    n_total++; if (o.lat !== 3) $display("FAIL word_ld_lat got %0d exp 3", o.lat); else n_pass++;
    n_total++; if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) $display("FAIL word_ld_data got %h/%b exp deadbeef/0", o.rdata, o.err); else n_pass++;
    n_total++; if (o.nwr !== 0) $display("FAIL word_ld_nowrite got %0d exp 0", o.nwr); else n_pass++;
  endtask

  task automatic test_subword;
    obs_t o, e;
    model_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, e);
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, o);
    model_txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h123456AA, e);
    run_txn(1'b1, 2'd0, 1'b0, 32'h12, 32'h123456AA, o);
    n_total++; if (o.lat !== 4) $display("FAIL byte_st_lat got %0d exp 4", o.lat); else n_pass++;
    n_total++; if (o.nwr !== 1 || o.wr_addr !== 10'd4 || o.wr_data !== 32'h11AA3344)
      $display("FAIL byte_st_rmw got n=%0d a=%h d=%h exp n=1 a=004 d=11aa3344", o.nwr, o.wr_addr, o.wr_data); else n_pass++;
    model_txn(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, e);
    run_txn(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, o);
    n_total++; if (o.rdata !== 32'hFFFFFFAA) $display("FAIL byte_ld_signed got %h exp ffffffaa", o.rdata); else n_pass++;
    model_txn(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, e);
    run_txn(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, o);
    n_total++; if (o.rdata !== 32'h000000AA) $display("FAIL byte_ld_unsigned got %h exp 000000aa", o.rdata); else n_pass++;
    model_txn(1'b1, 2'd2, 1'b0, 32'h14, 32'h0, e);
    run_txn(1'b1, 2'd2, 1'b0, 32'h14, 32'h0, o);
    model_txn(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF8001, e);
    run_txn(1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF8001, o);
    n_total++; if (o.wr_addr !== 10'd5 || o.wr_data !== 32'h80010000 || o.lat !== 4)
      $display("FAIL half_st_rmw got a=%h d=%h lat=%0d exp a=005 d=80010000 lat=4", o.wr_addr, o.wr_data, o.lat); else n_pass++;
    model_txn(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, e);
    run_txn(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, o);
    n_total++; if (o.rdata !== 32'hFFFF8001) $display("FAIL half_ld_signed got %h exp ffff8001", o.rdata); else n_pass++;
  endtask

  task automatic test_misaligned;
    obs_t o, e;
    model_txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, o);
    if (align_en) begin
      n_total++; if (o.err !== 1'b1 || o.lat !== 1 || o.rdata !== 32'h0)
        $display("FAIL misalign_err got err=%b lat=%0d rd=%h exp 1/1/0", o.err, o.lat, o.rdata); else n_pass++;
    end else begin
      n_total++; if (o.err !== 1'b0 || o.lat !== 3 || o.rdata !== 32'h11AA3344)
        $display("FAIL misalign_forced got err=%b lat=%0d rd=%h exp 0/3/11aa3344", o.err, o.lat, o.rdata); else n_pass++;
    end
    n_total++; if (o.nwr !== 0) $display("FAIL misalign_nowrite got %0d exp 0", o.nwr); else n_pass++;
  endtask

  task automatic test_reserved_size;
    obs_t o, e;
    for (int we = 0; we < 2; we++) begin
      model_txn(1'(we), 2'd3, 1'b0, 32'h20, 32'hCAFEF00D, e);
      run_txn(1'(we), 2'd3, 1'b0, 32'h20, 32'hCAFEF00D, o);
      n_total++; if (o.err !== 1'b1 || o.lat !== 1 || o.rdata !== 32'h0 || o.nwr !== 0)
        $display("FAIL size11_we%0d got err=%b lat=%0d rd=%h nwr=%0d exp 1/1/0/0", we, o.err, o.lat, o.rdata, o.nwr); else n_pass++;
    end
  endtask

  task automatic test_wrap;
    obs_t o, e;
    model_txn(1'b1, 2'd2, 1'b0, 32'hABCD_1020, 32'h5A5A0001, e);
    run_txn(1'b1, 2'd2, 1'b0, 32'hABCD_1020, 32'h5A5A0001, o);
    n_total++; if (o.wr_addr !== 10'd8 || o.err !== 1'b0) $display("FAIL wrap_addr got a=%h err=%b exp a=008 err=0", o.wr_addr, o.err); else n_pass++;
    model_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, o);
    n_total++; if (o.rdata !== 32'h5A5A0001) $display("FAIL wrap_readback got %h exp 5a5a0001", o.rdata); else n_pass++;
  endtask

  task automatic test_reset_mid;
    obs_t o, e;
    int base;
    bus.i_req_we = 1'b1; bus.i_req_size = 2'd0; bus.i_req_signed = 1'b0;
    bus.i_req_addr = 32'h31; bus.i_req_wdata = 32'h77; bus.i_req_valid = 1'b1;
    if (!bus.o_req_ready) @(negedge clk);
    base = wr_cnt;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (bus.o_req_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", bus.o_req_ready); else n_pass++;
    n_total++; if ({bus.o_resp_valid, bus.o_err, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_data, bus.o_resp_rdata} !== 77'h0)
      $display("FAIL midrst_outputs got rv=%b e=%b we=%b a=%h d=%h rd=%h exp all 0", bus.o_resp_valid, bus.o_err,
               bus.o_ram_we, bus.o_ram_addr, bus.o_ram_data, bus.o_resp_rdata); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++; if (bus.o_resp_valid !== 1'b0) $display("FAIL midrst_noresp[%0d] got %b exp 0", k, bus.o_resp_valid); else n_pass++;
    end
    n_total++; if (wr_cnt - base !== 0) $display("FAIL midrst_nowrite got %0d exp 0", wr_cnt - base); else n_pass++;
    model_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, o);
    n_total++; if (o.rdata !== e.rdata) $display("FAIL midrst_mem got %h exp %h", o.rdata, e.rdata); else n_pass++;
  endtask

  task automatic test_back_to_back;
    obs_t o, e;
    for (int i = 0; i < 6; i++) begin
      logic we;
      logic [1:0] sz;
      we = 1'(i % 2 == 0);
      sz = 2'(i % 3);
      model_txn(we, sz, 1'b1, 32'h40 + 32'(i), 32'h8000_8080 + 32'(i), e);
      run_txn(we, sz, 1'b1, 32'h40 + 32'(i), 32'h8000_8080 + 32'(i), o);
      n_total++; if (o.wait_cyc !== 1) $display("FAIL b2b_accept[%0d] got wait %0d exp 1", i, o.wait_cyc); else n_pass++;
      n_total++; if (o.rdata !== e.rdata || o.lat !== e.lat || o.err !== e.err)
        $display("FAIL b2b_resp[%0d] got rd=%h lat=%0d err=%b exp rd=%h lat=%0d err=%b", i, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err); else n_pass++;
    end
  endtask

  task automatic test_random;
    obs_t o, e;
    for (int i = 0; i < 300; i++) begin
      logic we, sgn;
      logic [1:0] sz;
      logic [31:0] addr, wd;
      we = 1'($urandom); sgn = 1'($urandom); sz = 2'($urandom_range(0, 3));
      addr = $urandom & 32'hFFFF_F03F; wd = $urandom;
      model_txn(we, sz, sgn, addr, wd, e);
      run_txn(we, sz, sgn, addr, wd, o);
      n_total++; if (o.lat !== e.lat) $display("FAIL rand_lat[%0d] got %0d exp %0d", i, o.lat, e.lat); else n_pass++;
      n_total++; if (o.err !== e.err || o.rdata !== e.rdata)
        $display("FAIL rand_resp[%0d] got err=%b rd=%h exp err=%b rd=%h", i, o.err, o.rdata, e.err, e.rdata); else n_pass++;
      n_total++; if (o.nwr !== e.nwr) $display("FAIL rand_nwr[%0d] got %0d exp %0d", i, o.nwr, e.nwr); else n_pass++;
      if (e.nwr == 1) begin
        n_total++; if (o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data)
          $display("FAIL rand_write[%0d] got a=%h d=%h exp a=%h d=%h", i, o.wr_addr, o.wr_data, e.wr_addr, e.wr_data); else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_size = 2'd0;
    bus.i_req_signed = 1'b0; bus.i_req_addr = 32'h0; bus.i_req_wdata = 32'h0;
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_reserved_size();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the CPU's single-port synchronous word RAM.
- Accepts byte/halfword/word load and store requests from the CPU datapath, drives the RAM address/data/write-enable pins, and returns formatted load data.
- The RAM has no byte enables, so sub-word stores are done as read-modify-write.
- Sits between the MEM pipeline stage and the data RAM.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; must match `RAM_ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width; must match `RAM_DATA_WIDTH; only 32 is supported.

Ports:
- i_clk  input  1  clock; the only clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_req_valid  input  1  request strobe; taken when i_req_valid & o_req_ready.
- o_req_ready  output  1  high only in IDLE.
- i_req_we  input  1  1 = store, 0 = load.
- i_req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- i_req_signed  input  1  sign-extend sub-word loads.
- i_req_addr  input  32  CPU byte address.
- i_req_wdata  input  32  store data; sub-word stores use the low bits.
- o_resp_valid  output  1  one-cycle completion pulse.
- o_resp_rdata  output  32  formatted load data; 0 for stores and errors.
- o_err  output  1  valid with o_resp_valid; misaligned access or size 11.
- o_ram_addr  output  ADDR_WIDTH  RAM word address = i_req_addr[ADDR_WIDTH+1:2]; upper bits ignored (wrap).
- o_ram_data  output  32  RAM write data.
- o_ram_we  output  1  RAM write enable.
- i_ram_data  input  32  RAM read data; valid the cycle after o_ram_addr is driven with o_ram_we=0.

Behaviour:
- All outputs except o_req_ready are registered. o_req_ready = (state==IDLE).
- Reset values: state IDLE; o_ram_we=0; o_ram_addr=0; o_ram_data=0; o_resp_valid=0; o_resp_rdata=0; o_err=0.
- Request capture: on accept, the request is latched. Inputs are ignored until the unit returns to IDLE.
- Byte lanes are little-endian: byte offset 0 = bits [7:0], offset 3 = [31:24]; halfword offset 2 = [31:16].
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP.
  - IDLE -> RESP: error request.
  - IDLE -> WR_ISSUE: word store.
  - IDLE -> RD_ISSUE: load or sub-word store.
  - RD_ISSUE -> RD_CAPTURE.
  - RD_CAPTURE -> RESP for a load; -> WR_ISSUE for a sub-word store.
  - WR_ISSUE -> RESP.
  - RESP -> IDLE.
- RD_ISSUE: o_ram_addr driven, o_ram_we=0.
- RD_CAPTURE: samples i_ram_data.
  - Load: extract the lane, zero- or sign-extend, register into o_resp_rdata.
  - Sub-word store: merge the i_req_wdata low byte/half into the addressed lane; other lanes keep old data; register into o_ram_data.
- WR_ISSUE: o_ram_we=1 for exactly one cycle, same o_ram_addr.
- RESP: o_resp_valid=1 for one cycle. o_err per the request. o_resp_rdata=0 for stores and errors.
- Latency, counted from the accept edge T to the cycle o_resp_valid is high:
  - error: T+1.
  - word store: T+2.
  - load: T+3.
  - sub-word store: T+4.
- Back-to-back: next accept is possible the cycle after RESP.
- Error requests never touch the RAM: o_ram_we stays 0.
- o_ram_we is 0 in every state except WR_ISSUE. o_ram_addr/o_ram_data hold their last values when unused.
- Reset mid-operation: returns to IDLE next edge with no response. A write already driven in the cycle where i_rst is high is committed by the RAM at that edge; no further RAM access follows.
- Address wrap: addresses above the RAM range alias modulo 2^ADDR_WIDTH words; no error.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: misaligned access raises o_err with no RAM access and 1-cycle latency. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Undefined: alignment bits are silently forced (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally. o_err is set only for size 11.

Test Plan:
- Word store 0xDEADBEEF @ 0x10, then word load @ 0x10 -> o_ram_we high 1 cycle with o_ram_addr=4; resp at T+2; load resp at T+3 with rdata=0xDEADBEEF, o_err=0.
- RAM word 4 = 0x11223344; byte store 0xAA @ 0x12 -> RMW writes 0x11AA3344; response at T+4; signed byte load @ 0x12 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half store 0x8001 @ 0x16 over word 5 = 0 -> word 5 = 0x80010000; signed half load @ 0x16 -> 0xFFFF8001.
- With MEM_ACCESS_ALIGN_CHECK_EN: word load @ 0x13 -> o_err=1 at T+1, rdata=0, o_ram_we never set. Without the macro: same request returns word 4.
- Size 11 request -> o_err=1 at T+1 in both builds.
- Assert i_rst while in RD_CAPTURE of a byte store -> no o_ram_we pulse, no o_resp_valid; all outputs at reset values; o_req_ready=1 next cycle.
